// File: rtl/b06_multi_ctrl.sv
// b06_multi_ctrl: round-robin multi-channel compare/acknowledge controller.
// Define B06_MULTI_CTRL_TIMEOUT_EN to build in the S_COUNT timeout and sticky TMO_ERR flag.
module b06_multi_ctrl #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned CHW       = $clog2(NCH),
  parameter int unsigned TMO_LIMIT = 200
) (
  input  logic           clock,
  input  logic           RESET_G,
  input  logic [NCH-1:0] EQL,
  input  logic           CONT_EQL,
  output logic [CHW-1:0] CC_MUX,
  output logic [1:0]     USCITE,
  output logic           ENABLE_COUNT,
  output logic           ACKOUT,
  output logic           BUSY,
  output logic           TMO_ERR
);

  // Encoding doubles as the USCITE phase code.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StSel   = 2'b01,
    StCount = 2'b10,
    StAck   = 2'b11
  } state_e;

  state_e         state_q;
  logic [CHW-1:0] ch_q;
  logic [CHW-1:0] ptr_q;
  logic [CHW-1:0] ptr_next;
  logic [CHW-1:0] win_idx;
  logic           win_found;
  int unsigned    scan;

  // First requesting channel at or above ptr_q, wrapping past NCH-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int i = 0; i < int'(NCH); i++) begin
      scan = (int'(ptr_q) + i) % NCH;
      if (!win_found && EQL[scan[CHW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[CHW-1:0];
      end
    end
  end

  // NCH need not be a power of two, so wrap explicitly.
  assign ptr_next = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + 1'b1;

`ifdef B06_MULTI_CTRL_TIMEOUT_EN
  logic [15:0] tcnt_q;
`else
  assign TMO_ERR = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (RESET_G) begin
      state_q      <= StIdle;
      ch_q         <= '0;
      ptr_q        <= '0;
      CC_MUX       <= '0;
      USCITE       <= 2'b00;
      ENABLE_COUNT <= 1'b0;
      ACKOUT       <= 1'b0;
      BUSY         <= 1'b0;
`ifdef B06_MULTI_CTRL_TIMEOUT_EN
      tcnt_q       <= '0;
      TMO_ERR      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q <= StSel;
            ch_q    <= win_idx;
            CC_MUX  <= win_idx;
            USCITE  <= 2'b01;
            BUSY    <= 1'b1;
          end
        end
        StSel: begin
          state_q      <= StCount;
          USCITE       <= 2'b10;
          ENABLE_COUNT <= 1'b1;
`ifdef B06_MULTI_CTRL_TIMEOUT_EN
          tcnt_q       <= '0;
`endif
        end
        StCount: begin
          if (CONT_EQL) begin
            state_q      <= StAck;
            USCITE       <= 2'b11;
            ENABLE_COUNT <= 1'b0;
            ACKOUT       <= 1'b1;
`ifdef B06_MULTI_CTRL_TIMEOUT_EN
          end else if (tcnt_q == 16'(TMO_LIMIT - 1)) begin
            // Abandon this grant; CONT_EQL has priority over this branch.
            state_q      <= StIdle;
            USCITE       <= 2'b00;
            ENABLE_COUNT <= 1'b0;
            BUSY         <= 1'b0;
            TMO_ERR      <= 1'b1;
            ptr_q        <= ptr_next;
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
`endif
          end
        end
        StAck: begin
          if (!EQL[ch_q]) begin
            state_q <= StIdle;
            USCITE  <= 2'b00;
            ACKOUT  <= 1'b0;
            BUSY    <= 1'b0;
            ptr_q   <= ptr_next;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_b06_multi_ctrl.sv
// Randomised and directed bench for b06_multi_ctrl against a cycle-level reference model.
module tb_b06_multi_ctrl;
  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;
  localparam int unsigned TMO = 8;
`ifdef B06_MULTI_CTRL_TIMEOUT_EN
  localparam bit TmoOn = 1'b1;
`else
  localparam bit TmoOn = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           RESET_G;
  logic [NCH-1:0] EQL;
  logic           CONT_EQL;
  logic [CHW-1:0] CC_MUX;
  logic [1:0]     USCITE;
  logic           ENABLE_COUNT;
  logic           ACKOUT;
  logic           BUSY;
  logic           TMO_ERR;

  always #5 clock = ~clock;

  b06_multi_ctrl #(
    .NCH      (NCH),
    .TMO_LIMIT(TMO)
  ) dut (
    .clock       (clock),
    .RESET_G     (RESET_G),
    .EQL         (EQL),
    .CONT_EQL    (CONT_EQL),
    .CC_MUX      (CC_MUX),
    .USCITE      (USCITE),
    .ENABLE_COUNT(ENABLE_COUNT),
    .ACKOUT      (ACKOUT),
    .BUSY        (BUSY),
    .TMO_ERR     (TMO_ERR)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 select, 2 count, 3 ack.
  int m_phase = 0;
  int m_ch    = 0;
  int m_ptr   = 0;
  int m_mux   = 0;
  int m_cnt   = 0;  // cycles already spent in the count phase
  bit m_err   = 1'b0;

  task automatic model_edge(input logic [NCH-1:0] e, input bit c, input bit r);
    bit found;
    if (r) begin
      m_phase = 0; m_ch = 0; m_ptr = 0; m_mux = 0; m_cnt = 0; m_err = 1'b0;
      return;
    end
    case (m_phase)
      0: begin
        found = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
          int k;
          k = (m_ptr + i) % NCH;
          if (!found && e[k]) begin
            found = 1'b1; m_ch = k; m_mux = k; m_phase = 1;
          end
        end
      end
      1: begin m_phase = 2; m_cnt = 0; end
      2: begin
        m_cnt = m_cnt + 1;
        if (c) m_phase = 3;
        else if (TmoOn && m_cnt >= int'(TMO)) begin
          m_err = 1'b1; m_phase = 0; m_ptr = (m_ch + 1) % NCH;
        end
      end
      default: begin
        if (!e[m_ch]) begin m_phase = 0; m_ptr = (m_ch + 1) % NCH; end
      end
    endcase
  endtask

  task automatic step(input logic [NCH-1:0] e, input bit c, input bit r);
    EQL = e; CONT_EQL = c; RESET_G = r;
    @(posedge clock);
    model_edge(e, c, r);
    @(negedge clock);
    check("cc_mux", 32'(CC_MUX), 32'(m_mux));
    check("uscite", 32'(USCITE), 32'(m_phase));
    check("enable_count", 32'(ENABLE_COUNT), 32'(m_phase == 2));
    check("ackout", 32'(ACKOUT), 32'(m_phase == 3));
    check("busy", 32'(BUSY), 32'(m_phase != 0));
    check("tmo_err", 32'(TMO_ERR), 32'(m_err));
  endtask

  // One full service of req; g reports the channel the DUT granted.
  task automatic grant_serve(input logic [NCH-1:0] req, output int g);
    logic [NCH-1:0] one;
    one = 1;
    step(req, 1'b0, 1'b0);
    g = int'(CC_MUX);
    step(req, 1'b0, 1'b0);
    step(req, 1'b0, 1'b0);
    step(req, 1'b1, 1'b0);
    step(req & ~(one << g), 1'b0, 1'b0);
  endtask

  initial begin
    int g;
    int exp_order[5];
    logic [NCH-1:0] e;
    bit c;
    bit r;
    int en_cycles;
    int ack_seen;
    exp_order = '{0, 1, 2, 3, 0};

    // Single request on channel 1, drop ignored until ack.
    step('0, 1'b0, 1'b1);
    check("reset_uscite", 32'(USCITE), 32'd0);
    step(4'b0010, 1'b0, 1'b0);
    check("s1_grant_mux", 32'(CC_MUX), 32'd1);
    check("s1_sel", 32'(USCITE), 32'd1);
    step(4'b0000, 1'b0, 1'b0);
    check("s1_count_en", 32'(ENABLE_COUNT), 32'd1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    check("s1_ack", 32'(ACKOUT), 32'd1);
    step(4'b0010, 1'b0, 1'b0);
    check("s1_ack_hold", 32'(ACKOUT), 32'd1);
    step(4'b0000, 1'b0, 1'b0);
    check("s1_idle_busy", 32'(BUSY), 32'd0);
    grant_serve(4'b1111, g);
    check("s1_ptr_after", 32'(g), 32'd2);

    // Round-robin with all channels requesting.
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      grant_serve(4'b1111, g);
      check("rr_order", 32'(g), 32'(exp_order[i]));
    end

    // Wrap: ptr=3 after serving channel 2.
    step('0, 1'b0, 1'b1);
    grant_serve(4'b0100, g);
    grant_serve(4'b0101, g);
    check("wrap_grant0", 32'(g), 32'd0);
    grant_serve(4'b0101, g);
    check("wrap_grant2", 32'(g), 32'd2);

    // Reset during ack with request still high.
    step('0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    check("rst_pre_ack", 32'(ACKOUT), 32'd1);
    step(4'b0001, 1'b0, 1'b1);
    check("rst_all_zero", 32'({CC_MUX, USCITE, ENABLE_COUNT, ACKOUT, BUSY, TMO_ERR}), 32'd0);
    step(4'b0001, 1'b0, 1'b0);
    check("rst_regrant_sel", 32'(USCITE), 32'd1);
    check("rst_regrant_mux", 32'(CC_MUX), 32'd0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);

`ifdef B06_MULTI_CTRL_TIMEOUT_EN
    // Timeout: enable high for exactly TMO cycles, no ack, sticky error.
    step('0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    en_cycles = 0;
    ack_seen  = 0;
    for (int i = 0; i < 12; i++) begin
      step('0, 1'b0, 1'b0);
      en_cycles += int'(ENABLE_COUNT);
      ack_seen  += int'(ACKOUT);
    end
    check("tmo_en_cycles", 32'(en_cycles), 32'(TMO));
    check("tmo_no_ack", 32'(ack_seen), 32'd0);
    check("tmo_err_set", 32'(TMO_ERR), 32'd1);
    check("tmo_idle", 32'(USCITE), 32'd0);
    grant_serve(4'b0010, g);
    check("tmo_err_sticky", 32'(TMO_ERR), 32'd1);
    step('0, 1'b0, 1'b1);
    check("tmo_err_cleared", 32'(TMO_ERR), 32'd0);

    // CONT_EQL on the last allowed count cycle wins over the timeout.
    step(4'b0001, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    for (int i = 0; i < int'(TMO) - 1; i++) step('0, 1'b0, 1'b0);
    check("tmo_edge_count", 32'(ENABLE_COUNT), 32'd1);
    step('0, 1'b1, 1'b0);
    check("tmo_edge_ack", 32'(ACKOUT), 32'd1);
    check("tmo_edge_noerr", 32'(TMO_ERR), 32'd0);
    step('0, 1'b0, 1'b0);
`else
    en_cycles = 0;
    ack_seen  = 0;
`endif

    // Randomised traffic.
    e = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) e = NCH'($urandom);
      c = ($urandom_range((n % 400) < 200 ? 3 : 30) == 0);
      r = ($urandom_range(249) == 0);
      step(e, c, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/b06_multi_ctrl.md
# b06_multi_ctrl

Parametrised multi-channel successor to the b06 compare/acknowledge controller. It arbitrates NCH request lines (EQL) round-robin and steers the counter-select mux to the winning channel. It enables the shared counter until CONT_EQL reports a match, then holds an acknowledge until the served channel drops its request. It sits between the per-channel comparators and the shared counter/output stage, and adds an optional counter-phase timeout with a sticky error flag.

## Interface
Parameters:
- NCH, 4, number of request channels; legal range 2..16.
- CHW, $clog2(NCH), width of the channel index; derived, not overridden.
- TMO_LIMIT, 200, maximum cycles in S_COUNT before timeout; legal range 2..2^16-1.

Ports:
- clock  in  1  single clock; all flops rise-edge triggered.
- RESET_G  in  1  reset, synchronous, active-high.
- EQL  in  NCH  per-channel request; level-sensitive.
- CONT_EQL  in  1  shared counter match; sampled only in S_COUNT.
- CC_MUX  out  CHW  index of the channel being served; registered.
- USCITE  out  2  phase code: 00 idle, 01 select, 10 count, 11 ack; registered.
- ENABLE_COUNT  out  1  counter enable; high only in S_COUNT.
- ACKOUT  out  1  acknowledge; high only in S_ACK.
- BUSY  out  1  high in every state except S_IDLE.
- TMO_ERR  out  1  sticky timeout flag.

## Operation
- The FSM has four states: S_IDLE, S_SEL, S_COUNT, S_ACK. Every output is a flop updated on the same edge as the state, so outputs always match the current state.
- Internal registers:
  - CH (CHW bits): latched grant.
  - PTR (CHW bits): round-robin start point.
  - TCNT (16 bits): timeout count; present only with the macro.
- S_IDLE:
  - Outputs: USCITE=00; ENABLE_COUNT, ACKOUT and BUSY all 0.
  - If EQL != 0, the winner is the first set bit scanning upward from PTR and wrapping past NCH-1 to 0.
  - On the winning edge: CH <= winner, CC_MUX <= winner, go to S_SEL.
- S_SEL: USCITE=01, BUSY=1; held for exactly one cycle, then go to S_COUNT.
- S_COUNT:
  - Outputs: USCITE=10, ENABLE_COUNT=1. TCNT starts at 0 on entry.
  - If CONT_EQL=1, go to S_ACK.
  - Otherwise TCNT increments; the timeout rule is under Configuration.
- S_ACK:
  - Outputs: USCITE=11, ACKOUT=1.
  - Stays in S_ACK while EQL[CH]=1.
  - When EQL[CH]=0: go to S_IDLE and set PTR <= (CH+1) mod NCH, where NCH is not necessarily a power of two.
- CC_MUX keeps its last value in S_IDLE; it changes only on a grant.
- Boundary conditions:
  - EQL[CH] falling in S_SEL or S_COUNT is ignored; the sequence completes and the drop is honoured in S_ACK.
  - Requests from other channels are ignored while BUSY=1.
  - If CONT_EQL is high on the S_SEL cycle, it is ignored there and acted on during the first S_COUNT cycle.
  - If CONT_EQL=1 in the same cycle as the timeout terminal count, CONT_EQL wins and the FSM goes to S_ACK with no error.
  - If only EQL[CH] remains set after service, the same channel is re-granted; starvation is impossible because PTR advances on every completion.
- Reset (synchronous, any state, mid-operation included):
  - State goes to S_IDLE.
  - CC_MUX=0, USCITE=00; ENABLE_COUNT, ACKOUT, BUSY, TMO_ERR all 0.
  - PTR=0, CH=0, TCNT=0.
  - Reset overrides every transition in the same cycle.

## Timing
- Request to select: EQL rising before edge k puts USCITE=01 and a valid CC_MUX after edge k, which is 1 cycle of latency.
- ENABLE_COUNT rises after edge k+1.
- CONT_EQL high before edge m (in S_COUNT) puts ACKOUT=1 after edge m.
- EQL[CH] low before edge n (in S_ACK) gives ACKOUT=0 and BUSY=0 after edge n. A new grant can occur at edge n+1, so the minimum back-to-back service is 4 cycles.
- There is no combinational path from any input to any output.

## Configuration
- Macro: B06_MULTI_CTRL_TIMEOUT_EN.
- Defined:
  - TCNT is built in.
  - If S_COUNT has lasted TMO_LIMIT cycles without CONT_EQL, the next edge sets TMO_ERR=1 and goes to S_IDLE.
  - On that edge ENABLE_COUNT falls, ACKOUT never pulses for this grant, and PTR <= (CH+1) mod NCH.
  - TMO_ERR stays high until RESET_G.
- Undefined:
  - No TCNT flops; TMO_ERR is tied 0.
  - S_COUNT waits indefinitely for CONT_EQL.
  - TMO_LIMIT is accepted but unused.

## Test plan
All scenarios use NCH=4 and TMO_LIMIT=8.
- Reset, then EQL=0010 for 1 cycle -> CC_MUX=1, USCITE sequence 01, 10 …; CONT_EQL pulse -> ACKOUT=1 until EQL[1]=0, then BUSY=0 and PTR=2.
- EQL=1111 held, CONT_EQL answered 2 cycles after each ENABLE_COUNT rise, EQL[CH] dropped and re-raised after each ACKOUT -> grants in order 0,1,2,3,0.
- PTR=3, EQL=0101 -> grant channel 0 (wrap); next grant with EQL=0101 is channel 2.
- Macro on, CONT_EQL held 0 -> ENABLE_COUNT high for exactly 8 cycles, then TMO_ERR=1, USCITE=00, no ACKOUT; TMO_ERR persists until RESET_G.
- Macro on, CONT_EQL=1 exactly on the 8th S_COUNT cycle -> S_ACK, TMO_ERR remains 0.
- RESET_G asserted for 1 cycle during S_ACK with EQL still high -> the next cycle shows every output 0; re-grant of that channel the cycle after reset deasserts, CC_MUX=0 path rechecked.
